// File: rtl/delta_liafn_scheduler_pkg.sv
// Shared definitions for the delta leaky-integrate scheduler.
//   - sched_state_e : scheduler FSM states
//   - DEF_*         : default threshold and leak shift
//   - *_W           : datapath widths (state, current, delta, event)
package delta_liafn_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_EMIT   = 2'd3
    } sched_state_e;

    localparam int unsigned DEF_DELTA_THRESH = 10;
    localparam int unsigned DEF_LEAK_SHIFT   = 3;

    localparam int unsigned STATE_W     = 8;
    localparam int unsigned CUR_W       = 8;
    localparam int unsigned SUM_W       = 10;
    localparam int unsigned DELTA_W     = STATE_W + 1;
    localparam int unsigned EVT_DELTA_W = 8;

    localparam logic [STATE_W-1:0] STATE_MAX = '1;

endpackage

// File: rtl/delta_liafn_scheduler_update.sv
// liafn_update_core: combinational leak/integrate/compare for one neuron.
//   s_i     : current membrane state
//   cur_i   : input current
//   prev_i  : previously committed state of this neuron
//   n_o     : new state, s - (s >> LEAK_SHIFT) + cur, saturated to 255
//   d_o     : signed n - prev
//   spike_o : d_o >= DELTA_THRESH (negative deltas never spike)
module liafn_update_core
    import delta_liafn_scheduler_pkg::*;
#(
    parameter int unsigned DELTA_THRESH = DEF_DELTA_THRESH,
    parameter int unsigned LEAK_SHIFT   = DEF_LEAK_SHIFT
) (
    input  logic        [STATE_W-1:0] s_i,
    input  logic        [CUR_W-1:0]   cur_i,
    input  logic        [STATE_W-1:0] prev_i,
    output logic        [STATE_W-1:0] n_o,
    output logic signed [DELTA_W-1:0] d_o,
    output logic                      spike_o
);

    localparam logic signed [DELTA_W-1:0] THRESH_S = DELTA_W'(DELTA_THRESH);

    function automatic logic [STATE_W-1:0] sat_state(input logic [SUM_W-1:0] v);
        if (v > SUM_W'(STATE_MAX)) begin
            return STATE_MAX;
        end
        return v[STATE_W-1:0];
    endfunction

    logic [SUM_W-1:0] leaked;
    logic [SUM_W-1:0] sum;

    // s - (s >> k) never underflows, so only the add can exceed 8 bits.
    assign leaked  = SUM_W'(s_i) - SUM_W'(s_i >> LEAK_SHIFT);
    assign sum     = leaked + SUM_W'(cur_i);
    assign n_o     = sat_state(sum);
    assign d_o     = $signed({1'b0, n_o}) - $signed({1'b0, prev_i});
    assign spike_o = (d_o >= THRESH_S);

endmodule

// File: rtl/delta_liafn_scheduler.sv
// delta_liafn_scheduler: time-multiplexes one delta-spiking LIF update over
// NUM_NEURONS virtual neurons, sweeping 0..NUM_NEURONS-1 on every tick.
//   clk, rst_n            : clock, async active-low reset
//   tick                  : starts one sweep (ignored while busy / at sweep_done)
//   cur_req/cur_idx       : current request for neuron cur_idx
//   cur_valid/cur_data    : current response, completes the request
//   evt_valid/evt_idx/evt_delta/evt_ready : delta event handshake
//   state_mon             : last committed membrane state
//   busy, sweep_done      : sweep in progress, one-cycle end-of-sweep pulse
//   overrun               : sticky, tick arrived while a sweep was active
module delta_liafn_scheduler
    import delta_liafn_scheduler_pkg::*;
#(
    parameter int unsigned NUM_NEURONS  = 4,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned DELTA_THRESH = DEF_DELTA_THRESH,
    parameter int unsigned LEAK_SHIFT   = DEF_LEAK_SHIFT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    output logic                   cur_req,
    output logic [IDX_W-1:0]       cur_idx,
    input  logic                   cur_valid,
    input  logic [CUR_W-1:0]       cur_data,
    output logic                   evt_valid,
    output logic [IDX_W-1:0]       evt_idx,
    output logic [EVT_DELTA_W-1:0] evt_delta,
    input  logic                   evt_ready,
    output logic [STATE_W-1:0]     state_mon,
    output logic                   busy,
    output logic                   sweep_done,
    output logic                   overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    sched_state_e state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CUR_W-1:0]       cur_q;
    logic [STATE_W-1:0]     mem_q  [NUM_NEURONS];
    logic [STATE_W-1:0]     prev_q [NUM_NEURONS];
    logic [IDX_W-1:0]       evt_idx_q;
    logic [EVT_DELTA_W-1:0] evt_delta_q;
    logic [STATE_W-1:0]     state_mon_q;
    logic                   sweep_done_q, sweep_done_d;
    logic                   overrun_q;

    logic lat_cur;
    logic commit;
    logic load_evt;
    logic is_last;
    logic start;

    logic        [STATE_W-1:0] n_val;
    logic signed [DELTA_W-1:0] d_val;
    logic                      spike;

    liafn_update_core #(
        .DELTA_THRESH (DELTA_THRESH),
        .LEAK_SHIFT   (LEAK_SHIFT)
    ) u_core (
        .s_i     (mem_q[idx_q]),
        .cur_i   (cur_q),
        .prev_i  (prev_q[idx_q]),
        .n_o     (n_val),
        .d_o     (d_val),
        .spike_o (spike)
    );

    assign is_last = (idx_q == LAST_IDX);
    // A tick landing on the sweep_done cycle is treated as an overrun, not a start.
    assign start   = tick && (state_q == ST_IDLE) && !sweep_done_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sweep_done_d = 1'b0;
        lat_cur      = 1'b0;
        commit       = 1'b0;
        load_evt     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: begin
                if (cur_valid) begin
                    lat_cur = 1'b1;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                commit = 1'b1;
                if (spike) begin
                    load_evt = 1'b1;
                    state_d  = ST_EMIT;
                end else if (is_last) begin
                    state_d      = ST_IDLE;
                    sweep_done_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    if (is_last) begin
                        state_d      = ST_IDLE;
                        sweep_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cur_q        <= '0;
            evt_idx_q    <= '0;
            evt_delta_q  <= '0;
            state_mon_q  <= '0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                mem_q[i]  <= '0;
                prev_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sweep_done_q <= sweep_done_d;
            if (tick && ((state_q != ST_IDLE) || sweep_done_q)) begin
                overrun_q <= 1'b1;
            end
            if (lat_cur) begin
                cur_q <= cur_data;
            end
            if (commit) begin
                mem_q[idx_q]  <= n_val;
                prev_q[idx_q] <= n_val;
                state_mon_q   <= n_val;
            end
            if (load_evt) begin
                evt_idx_q   <= idx_q;
                evt_delta_q <= d_val[EVT_DELTA_W-1:0];
            end
        end
    end

    assign cur_req    = (state_q == ST_FETCH);
    assign cur_idx    = idx_q;
    assign evt_valid  = (state_q == ST_EMIT);
    assign evt_idx    = evt_idx_q;
    assign evt_delta  = evt_delta_q;
    assign state_mon  = state_mon_q;
    assign busy       = (state_q != ST_IDLE);
    assign sweep_done = sweep_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_delta_liafn_scheduler.sv
module tb_delta_liafn_scheduler;

    localparam int N      = 4;
    localparam int THRESH = 10;
    localparam int LEAK   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       cur_req;
    logic [1:0] cur_idx;
    logic       cur_valid = 1'b0;
    logic [7:0] cur_data = 8'd0;
    logic       evt_valid;
    logic [1:0] evt_idx;
    logic [7:0] evt_delta;
    logic       evt_ready = 1'b0;
    logic [7:0] state_mon;
    logic       busy;
    logic       sweep_done;
    logic       overrun;

    delta_liafn_scheduler #(
        .NUM_NEURONS  (N),
        .IDX_W        (2),
        .DELTA_THRESH (THRESH),
        .LEAK_SHIFT   (LEAK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .cur_req    (cur_req),
        .cur_idx    (cur_idx),
        .cur_valid  (cur_valid),
        .cur_data   (cur_data),
        .evt_valid  (evt_valid),
        .evt_idx    (evt_idx),
        .evt_delta  (evt_delta),
        .evt_ready  (evt_ready),
        .state_mon  (state_mon),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model and scoreboard
    int model_state [N];
    int model_prev  [N];
    int cur_tab     [N];
    int exp_eidx  [$];
    int exp_edel  [$];
    int exp_fetch [$];
    int exp_cycles;
    int last_n;

    // agent controls
    bit zero_wait  = 1'b1;
    bit rnd_ready  = 1'b0;
    int bp_left    = 0;
    bit bp_held    = 1'b0;
    bit resume_chk = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            model_state[i] = 0;
            model_prev[i]  = 0;
        end
        exp_eidx.delete();
        exp_edel.delete();
        exp_fetch.delete();
        bp_left = 0;
        bp_held = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) cur_tab[i] = v;
    endtask

    // Sweep outcome straight from the neuron equations.
    task automatic plan_sweep(input int bp);
        int spikes;
        spikes = 0;
        for (int i = 0; i < N; i++) begin
            int s, n, d;
            s = model_state[i];
            n = s - s / (1 << LEAK) + cur_tab[i];
            if (n > 255) n = 255;
            d = n - model_prev[i];
            exp_fetch.push_back(i);
            if (d >= THRESH) begin
                exp_eidx.push_back(i);
                exp_edel.push_back(d % 256);
                spikes++;
            end
            model_state[i] = n;
            model_prev[i]  = n;
            last_n = n;
        end
        exp_cycles = 3 * spikes + 2 * (N - spikes) + 1 + bp;
    endtask

    task automatic start_sweep(input int bp);
        plan_sweep(bp);
        bp_left = bp;
        @(negedge clk);
        tick = 1'b1;
    endtask

    task automatic finish_sweep(input bit chk_len, input int busy_tick_k, input bit tick_on_done);
        bit done;
        done = 1'b0;
        for (int k = 1; k <= 3000 && !done; k++) begin
            @(negedge clk);
            tick = 1'b0;
            if (k == 1) check("busy_start", int'(busy), 1);
            if (k == busy_tick_k) tick = 1'b1;
            if (sweep_done) begin
                done = 1'b1;
                if (chk_len) check("sweep_len", k, exp_cycles);
                check("state_mon", int'(state_mon), last_n);
                if (tick_on_done) tick = 1'b1;
            end
        end
        if (!done) check("sweep_timeout", 0, 1);
        @(negedge clk);
        tick = 1'b0;
        check("done_pulse", int'(sweep_done), 0);
        check("idle_busy", int'(busy), 0);
        check("evt_left", exp_eidx.size(), 0);
        check("fetch_left", exp_fetch.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cur_req"},    int'(cur_req), 0);
        check({tag, "_cur_idx"},    int'(cur_idx), 0);
        check({tag, "_evt_valid"},  int'(evt_valid), 0);
        check({tag, "_evt_idx"},    int'(evt_idx), 0);
        check({tag, "_evt_delta"},  int'(evt_delta), 0);
        check({tag, "_state_mon"},  int'(state_mon), 0);
        check({tag, "_busy"},       int'(busy), 0);
        check({tag, "_sweep_done"}, int'(sweep_done), 0);
        check({tag, "_overrun"},    int'(overrun), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        tick  = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor/driver: serves current requests, consumes events and pops the scoreboard.
    always @(negedge clk) begin : agent
        int e;
        if (!rst_n) begin
            cur_valid  = 1'b0;
            evt_ready  = 1'b0;
            resume_chk = 1'b0;
        end else begin
            if (resume_chk) begin
                check("bp_resume", int'(cur_req), 1);
                resume_chk = 1'b0;
            end
            if (cur_req) begin
                if (zero_wait || $urandom_range(0, 2) == 0) begin
                    cur_valid = 1'b1;
                    if (exp_fetch.size() == 0) begin
                        check("fetch_extra", 1, 0);
                        cur_data = 8'd0;
                    end else begin
                        e = exp_fetch.pop_front();
                        check("cur_idx", int'(cur_idx), e);
                        cur_data = 8'(cur_tab[e]);
                    end
                end else begin
                    cur_valid = 1'b0;
                    cur_data  = 8'($urandom);
                end
            end else begin
                cur_valid = zero_wait ? 1'b0 : 1'($urandom_range(0, 1));
                cur_data  = 8'($urandom);
            end
            if (evt_valid) begin
                if (bp_left > 0) begin
                    evt_ready = 1'b0;
                    bp_left--;
                    bp_held = 1'b1;
                    check("bp_no_req", int'(cur_req), 0);
                    if (exp_eidx.size() > 0) begin
                        check("bp_idx_stable", int'(evt_idx), exp_eidx[0]);
                        check("bp_delta_stable", int'(evt_delta), exp_edel[0]);
                    end
                end else if (!rnd_ready || $urandom_range(0, 1) == 1) begin
                    evt_ready = 1'b1;
                    if (exp_eidx.size() == 0) begin
                        check("evt_extra", 1, 0);
                    end else begin
                        e = exp_eidx.pop_front();
                        check("evt_idx", int'(evt_idx), e);
                        check("evt_delta", int'(evt_delta), exp_edel.pop_front());
                        if (bp_held && e != N - 1) resume_chk = 1'b1;
                        bp_held = 1'b0;
                    end
                end else begin
                    evt_ready = 1'b0;
                end
            end else begin
                evt_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");
        #2;
        rst_n = 1'b1;

        // basic sweeps, zero-wait handshakes
        zero_wait = 1'b1;
        rnd_ready = 1'b0;
        set_all(20); start_sweep(0); finish_sweep(1'b1, 0, 1'b0);
        set_all(20); start_sweep(0); finish_sweep(1'b1, 0, 1'b0);
        set_all(0);  start_sweep(0); finish_sweep(1'b1, 0, 1'b0);
        check("after_decay_mon", int'(state_mon), 34);
        check("no_overrun_yet", int'(overrun), 0);

        // tick while busy
        set_all(30); start_sweep(0); finish_sweep(1'b1, 3, 1'b0);
        check("overrun_busy", int'(overrun), 1);

        // saturation, then tick coincident with sweep_done
        do_reset();
        check("rst2_overrun", int'(overrun), 0);
        set_all(250); start_sweep(0); finish_sweep(1'b1, 0, 1'b0);
        set_all(100); start_sweep(0); finish_sweep(1'b1, 0, 1'b1);
        check("sat_mon", int'(state_mon), 255);
        check("overrun_done", int'(overrun), 1);

        // backpressure on the first event
        do_reset();
        set_all(20); start_sweep(5); finish_sweep(1'b1, 0, 1'b0);

        // randomized handshakes and currents
        do_reset();
        zero_wait = 1'b0;
        rnd_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) cur_tab[i] = $urandom_range(0, 80);
            start_sweep(($urandom_range(0, 3) == 0) ? 3 : 0);
            finish_sweep(1'b0, 0, 1'b0);
        end

        // reset in the middle of a held event
        do_reset();
        zero_wait = 1'b1;
        rnd_ready = 1'b0;
        set_all(30);
        start_sweep(1000);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                tick = 1'b0;
                if (evt_valid) seen = 1'b1;
            end
            check("emit_reached", int'(seen), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        clear_model();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        set_all(15); start_sweep(0); finish_sweep(1'b1, 0, 1'b0);
        check("post_rst_mon", int'(state_mon), 15);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delta_liafn_scheduler.md
Name: delta_liafn_scheduler

Overview:
- Time-multiplexes one leaky-integrate delta-spiking update datapath across NUM_NEURONS virtual neurons.
- On each `tick`, sweeps neurons 0..NUM_NEURONS-1 in order. Per neuron it:
  - fetches an input current over a req/valid handshake;
  - applies leak plus integration with saturation;
  - compares the result against that neuron's stored previous state;
  - emits a delta event over a valid/ready handshake when the delta reaches threshold.
- Sits between the input-current source and the spike/event consumer at the top level.

Parameters:
- NUM_NEURONS, 4, number of virtual neurons; power of two, 2..16.
- IDX_W, 2, clog2(NUM_NEURONS).
- DELTA_THRESH, 10, unsigned 8-bit spike threshold on (new - prev).
- LEAK_SHIFT, 3, leak = state >> LEAK_SHIFT; range 1..7.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  single-cycle pulse that starts one sweep
- cur_req  out  1  request current for neuron cur_idx
- cur_idx  out  IDX_W  neuron whose current is requested
- cur_valid  in  1  cur_data valid; completes the request
- cur_data  in  8  unsigned input current
- evt_valid  out  1  delta event pending
- evt_idx  out  IDX_W  neuron that spiked
- evt_delta  out  8  new - prev, low 8 bits
- evt_ready  in  1  consumer accepts event
- state_mon  out  8  last committed membrane state
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at sweep end
- overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - All membrane states and previous states cleared to 0.
  - Every output is 0, including the overrun flag.
  - Reset mid-sweep aborts the sweep immediately; nothing partial is retained.
- FSM states: IDLE, FETCH, UPDATE, EMIT.
- IDLE:
  - busy=0.
  - tick=1 → FETCH with idx=0; busy=1 from the next cycle.
- FETCH:
  - cur_req=1 and cur_idx=idx, held stable until cur_valid=1.
  - cur_data is sampled in the cycle cur_valid=1, then → UPDATE.
  - cur_valid while cur_req=0 is ignored.
- UPDATE (exactly one cycle):
  - s = state[idx].
  - n = s - (s >> LEAK_SHIFT) + cur, computed in 10 bits and saturated to 255.
  - d = n - prev[idx], signed 9-bit.
  - spike = (d >= DELTA_THRESH), signed compare; negative deltas never spike.
  - Writes state[idx]=n and prev[idx]=n, and sets state_mon=n.
  - spike=1: load evt_idx=idx and evt_delta=d[7:0], then → EMIT.
  - spike=0: if idx is last → IDLE with sweep_done=1; otherwise idx+1 → FETCH.
- EMIT:
  - evt_valid=1, with evt_idx and evt_delta held stable until evt_ready=1.
  - Transfer occurs on the cycle evt_valid && evt_ready.
  - evt_valid drops the next cycle.
  - Next state follows the same last/next rule as UPDATE.
  - evt_ready while evt_valid=0 is ignored.
- Latency with zero handshake waits:
  - tick at cycle T → cur_req at T+1.
  - cur_valid at T+1 → UPDATE at T+2.
  - Each neuron takes 2 cycles, or 3 if it spikes.
- tick while busy: ignored and sets overrun=1, which stays set until reset.
- tick in the same cycle that sweep_done pulses is also ignored and sets overrun.
- idx does not wrap mid-sweep; the sweep always ends after neuron NUM_NEURONS-1.
- busy is 1 in FETCH, UPDATE and EMIT only.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/FETCH/UPDATE/EMIT);
  - default constants DELTA_THRESH=10 and LEAK_SHIFT=3;
  - event width constants.
- One natural sub-module, liafn_update_core: purely combinational (s, cur, prev) → (n, d, spike), holding the leak, saturation and compare arithmetic.
- State and previous-state storage live as register arrays in the scheduler.

Test Plan:
- Reset then one tick, cur_data=20 for all neurons with zero-wait handshakes → 4 events (idx 0..3, delta 20), state_mon=20, sweep_done at T+13.
- Second tick, cur_data=20 → n = 20 - 2 + 20 = 38, d=18, 4 events with delta 18; a third tick with cur_data=0 → n=34, d=-4, no events, sweep takes 8 cycles.
- Saturation: drive neuron 0 to state 250, then cur_data=100 → 250 - 31 + 100 = 319, saturated to 255; d = 255 - 250 = 5, no spike.
- Backpressure: hold evt_ready=0 for 5 cycles on a spike → evt_valid/evt_idx/evt_delta stable, no cur_req in that window, sweep resumes one cycle after acceptance.
- Tick while busy and tick coincident with sweep_done → ignored, overrun=1, event count unchanged.
- Assert rst_n=0 in EMIT with cur_req stalled → all outputs 0 immediately; the next sweep with cur_data=15 yields delta 15 events for every neuron.
